// File: rtl/pip_pkg.sv
// Shared pipeline encodings: ALU op codes, register index width, control bit positions.
package pip_pkg;

  localparam int REG_W  = 5;
  localparam int CTRL_W = 3;

  // ex_ctrl / id_ctrl layout is {regwrite, memtoreg, memwrite}
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_OR  = 2'b10,
    ALU_SLT = 2'b11
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks EX/MEM result, then MEM/WB result, else the registered value.
module fwd_mux
  import pip_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [REG_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic [REG_W-1:0]  exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic [REG_W-1:0]  memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic [DATA_W-1:0] operand_o
);

  logic hit_exmem;
  logic hit_memwb;

  // r0 is hardwired, so it never takes a forwarded value
  assign hit_exmem = (idx_i != '0) && (idx_i == exmem_rd_i);
  assign hit_memwb = (idx_i != '0) && (idx_i == memwb_rd_i);

  assign operand_o = hit_exmem ? exmem_result_i :
                     hit_memwb ? memwb_result_i : reg_data_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and operand forwarding.
// Define ID_EX_FWD_EN to enable forwarding; otherwise any RAW hazard stalls.
module id_ex_stage
  import pip_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alusrc,
  input  logic [2:0]        id_ctrl,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic [4:0]        exmem_rd,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        ex_alu_op,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [2:0]        ex_ctrl
);

  logic              valid_q, valid_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  alu_op_e           alu_op_q, alu_op_d;
  logic              alusrc_q, alusrc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic [REG_W-1:0]  fwd_exmem_rd, fwd_memwb_rd;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              hazard;

`ifdef ID_EX_FWD_EN
  assign fwd_exmem_rd = exmem_rd;
  assign fwd_memwb_rd = memwb_rd;
  // Only a load in EX cannot be covered by forwarding
  assign hazard = valid_q && ctrl_q[CTRL_MEMTOREG] && (rd_q != '0) && id_valid &&
                  ((rd_q == id_rs) || (rd_q == id_rt));
`else
  logic rs_raw, rt_raw;
  logic unused_memwb_rd;

  // Forwarding disabled: tying the forward indices to r0 makes the muxes pass registered data
  assign fwd_exmem_rd    = '0;
  assign fwd_memwb_rd    = '0;
  assign unused_memwb_rd = ^memwb_rd;
  assign rs_raw = (id_rs != '0) &&
                  ((valid_q && ctrl_q[CTRL_REGWRITE] && (rd_q == id_rs)) || (exmem_rd == id_rs));
  assign rt_raw = (id_rt != '0) &&
                  ((valid_q && ctrl_q[CTRL_REGWRITE] && (rd_q == id_rt)) || (exmem_rd == id_rt));
  assign hazard = id_valid && (rs_raw || rt_raw);
`endif

  assign load_use_stall = hazard && !ex_hold;

  always_comb begin
    valid_d   = valid_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    alu_op_d  = alu_op_q;
    alusrc_d  = alusrc_q;
    ctrl_d    = ctrl_q;
    // Flush overrides hold; a stall inserts a bubble while ID waits
    if (flush || load_use_stall) begin
      valid_d   = 1'b0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      alu_op_d  = ALU_ADD;
      alusrc_d  = 1'b0;
      ctrl_d    = '0;
    end else if (!ex_hold) begin
      valid_d   = id_valid;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      alu_op_d  = alu_op_e'(id_alu_op);
      alusrc_d  = id_alusrc;
      ctrl_d    = id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      alu_op_q  <= ALU_ADD;
      alusrc_q  <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      alu_op_q  <= alu_op_d;
      alusrc_q  <= alusrc_d;
      ctrl_q    <= ctrl_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
    .idx_i          (rs_q),
    .reg_data_i     (rs_data_q),
    .exmem_rd_i     (fwd_exmem_rd),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (fwd_memwb_rd),
    .memwb_result_i (memwb_result),
    .operand_o      (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
    .idx_i          (rt_q),
    .reg_data_i     (rt_data_q),
    .exmem_rd_i     (fwd_exmem_rd),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (fwd_memwb_rd),
    .memwb_result_i (memwb_result),
    .operand_o      (rt_fwd)
  );

  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_ctrl       = ctrl_q;
  assign ex_alu_op     = alu_op_q;
  assign alu_a         = rs_fwd;
  assign alu_b         = alusrc_q ? imm_q : rt_fwd;
  assign ex_store_data = rt_fwd;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width of operands, immediate, forwarded results.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  ID holds a real instruction.
REQ-005 id_rs / id_rt / id_rd  input  5 each  source and destination register indices; id_rd=0 means no write.
REQ-006 id_rs_data / id_rt_data  input  DATA_W each  register-file read data.
REQ-007 id_imm  input  DATA_W  extended immediate.
REQ-008 id_alu_op  input  2  ALU op: 00 add, 01 sub, 10 or, 11 slt.
REQ-009 id_alusrc  input  1  1 selects immediate as ALU B operand.
REQ-010 id_ctrl  input  3  {regwrite, memtoreg, memwrite}.
REQ-011 flush  input  1  squash the instruction entering EX (branch/jump redirect).
REQ-012 ex_hold  input  1  downstream stall; freeze EX contents.
REQ-013 exmem_rd / memwb_rd  input  5 each  destination of MEM/WB instruction; 0 means no write.
REQ-014 exmem_result / memwb_result  input  DATA_W each  forwardable results.
REQ-015 load_use_stall  output  1  combinational; IF/ID must hold this cycle.
REQ-016 ex_valid  output  1  EX holds a real instruction.
REQ-017 alu_a / alu_b  output  DATA_W each  final ALU operands.
REQ-018 ex_alu_op  output  2  registered ALU op.
REQ-019 ex_rd  output  5  registered destination; 0 for a bubble.
REQ-020 ex_store_data  output  DATA_W  forwarded rt value for stores.
REQ-021 ex_ctrl  output  3  registered {regwrite, memtoreg, memwrite}; 000 for a bubble.

Function
REQ-022 Per-edge priority SHALL be: reset > flush > ex_hold > load_use_stall > load; flush and load_use_stall each load a bubble (all fields zero).
REQ-023 ex_hold without flush SHALL keep every register unchanged; load_use_stall SHALL be forced low while ex_hold is high.
REQ-024 Load SHALL capture all id_* fields with one-cycle latency; ex_valid <= id_valid.
REQ-025 load_use_stall SHALL be 1 iff ex_valid, ex_ctrl memtoreg=1, ex_rd!=0, id_valid, and ex_rd equals id_rs or id_rt.
REQ-026 Forwarded rs/rt (FWD_EN defined) SHALL use exmem_result if index!=0 and equals exmem_rd, else memwb_result if equals memwb_rd, else registered data; EX/MEM wins when both match.
REQ-027 Register 0 SHALL never be forwarded; its operand is the registered value.
REQ-028 alu_a SHALL be forwarded rs; alu_b SHALL be id_imm registered when alusrc=1, else forwarded rt; ex_store_data is always forwarded rt.
REQ-029 Operand muxing SHALL be purely combinational from registered state plus forwarding inputs, no added latency.

Reset
REQ-030 On reset all registers SHALL clear: ex_valid=0, ex_rd=0, ex_ctrl=000, ex_alu_op=00, data/imm=0; reset mid-stall or mid-hold discards the held instruction.

Configuration
REQ-031 Macro ID_EX_FWD_EN: defined -> forwarding per REQ-026/027 and stall per REQ-025.
REQ-032 Undefined -> no forwarding (operands are registered data); load_use_stall SHALL assert for any RAW where id_rs or id_rt (nonzero) matches a valid ex_rd with regwrite, or exmem_rd.

Structure
REQ-033 Package pip_pkg SHALL hold ALU op encodings (ALU_ADD/SUB/OR/SLT), register index width 5, ctrl bit positions.
REQ-034 One sub-module fwd_mux (index, registered data, two forward sources -> operand) SHALL be instantiated twice.

Verification
REQ-035 Load rs=3 data 5, rt=4 data 7, alu_op=01, alusrc=0 -> next cycle alu_a=5, alu_b=7, ex_alu_op=01, ex_valid=1.
REQ-036 EX rs=8 (reg data 1); exmem_rd=8 result 0x20; memwb_rd=8 result 0x30 -> alu_a=0x20; clear exmem_rd -> alu_a=0x30.
REQ-037 EX is lw to rd=9; ID uses rt=9 -> load_use_stall=1, next cycle ex_valid=0, ex_ctrl=000; ID instruction enters following cycle.
REQ-038 flush and ex_hold both high with valid ID -> bubble loaded; ex_hold alone for 3 cycles -> outputs unchanged.
REQ-039 rs=0 with exmem_rd=0 result 0xFFFF -> alu_a equals registered rs data (0); reset pulse mid-hold -> ex_valid=0 next edge.
